// File: rtl/colorbar_gen.sv
// Test-pattern generator: turns the video timing stream into RGB pixels.
// Two-stage pipeline: stage 1 captures syncs/DE plus the pixel coordinates,
// stage 2 produces the pattern colour and the twice-delayed syncs.
module colorbar_gen #(
    parameter int          H_ACTIVE    = 1280,
    parameter int          V_ACTIVE    = 720,
    parameter logic        SYNC_POL    = 1'b1,
    parameter int          CHECK_SHIFT = 5,
    parameter int          GRAD_SHIFT  = 2,
    parameter logic [23:0] SOLID_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [1:0]  mode,
    output logic [23:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter widths must also hold the bits the gradient and checkerboard pick out.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int X_W   = imax(imax($clog2(H_ACTIVE), GRAD_SHIFT + 8), CHECK_SHIFT + 1);
    localparam int Y_W   = imax($clog2(V_ACTIVE), CHECK_SHIFT + 1);
    localparam int S_W   = imax(1, $clog2(BAR_W));

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);
    localparam logic [S_W-1:0] S_MAX = S_W'(BAR_W - 1);

    // Running coordinate counters (value before increment is the current pixel).
    logic [X_W-1:0] r_x_cnt;
    logic [S_W-1:0] r_sub_cnt;
    logic [2:0]     r_bar_cnt;
    logic [Y_W-1:0] r_y_cnt;
    logic [1:0]     r_mode;

    // Stage 1: delayed timing plus only the coordinate pieces the patterns use.
    logic       r_de1;
    logic       r_hs1;
    logic       r_vs1;
    logic [2:0] r_bar1;
    logic [7:0] r_grey1;
    logic       r_xchk1;
    logic       r_ychk1;

    // Stage 2: output registers.
    logic [23:0] r_rgb2;
    logic        r_de2;
    logic        r_hs2;
    logic        r_vs2;

    logic        w_vs_edge;
    logic        w_de_fall;
    logic [23:0] w_pattern;

    // Stage-1 registers double as the previous-cycle history for edge detection.
    assign w_vs_edge = (vsync_in == SYNC_POL) && (r_vs1 != SYNC_POL);
    assign w_de_fall = r_de1 && !de_in;

    // Horizontal position and bar tracking without a divider: a sub-counter
    // walks each bar width and bumps the bar index when it wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_cnt   <= '0;
            r_sub_cnt <= '0;
            r_bar_cnt <= '0;
        end else if (de_in) begin
            if (r_x_cnt != X_MAX) begin
                r_x_cnt <= r_x_cnt + X_W'(1);
            end
            if (r_sub_cnt == S_MAX) begin
                r_sub_cnt <= '0;
                if (r_bar_cnt != 3'd7) begin
                    r_bar_cnt <= r_bar_cnt + 3'd1;
                end
            end else begin
                r_sub_cnt <= r_sub_cnt + S_W'(1);
            end
        end else begin
            r_x_cnt   <= '0;
            r_sub_cnt <= '0;
            r_bar_cnt <= '0;
        end
    end

    // Line counter and frame-start mode capture; a vsync edge beats a DE fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_cnt <= '0;
            r_mode  <= 2'd0;
        end else if (w_vs_edge) begin
            r_y_cnt <= '0;
            r_mode  <= mode;
        end else if (w_de_fall && (r_y_cnt != Y_MAX)) begin
            r_y_cnt <= r_y_cnt + Y_W'(1);
        end
    end

    // Stage 1: capture timing and the coordinate bits of the current pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de1   <= 1'b0;
            r_hs1   <= ~SYNC_POL;
            r_vs1   <= ~SYNC_POL;
            r_bar1  <= '0;
            r_grey1 <= '0;
            r_xchk1 <= 1'b0;
            r_ychk1 <= 1'b0;
        end else begin
            r_de1   <= de_in;
            r_hs1   <= hsync_in;
            r_vs1   <= vsync_in;
            r_bar1  <= r_bar_cnt;
            r_grey1 <= r_x_cnt[GRAD_SHIFT+7:GRAD_SHIFT];
            r_xchk1 <= r_x_cnt[CHECK_SHIFT];
            r_ychk1 <= r_y_cnt[CHECK_SHIFT];
        end
    end

    // Pattern colour for the pixel held in stage 1, selected by the frame's mode.
    always_comb begin
        w_pattern = 24'h000000;
        case (r_mode)
            2'd0: begin
                case (r_bar1)
                    3'd0: w_pattern = 24'hFFFFFF;
                    3'd1: w_pattern = 24'hFFFF00;
                    3'd2: w_pattern = 24'h00FFFF;
                    3'd3: w_pattern = 24'h00FF00;
                    3'd4: w_pattern = 24'hFF00FF;
                    3'd5: w_pattern = 24'hFF0000;
                    3'd6: w_pattern = 24'h0000FF;
                    3'd7: w_pattern = 24'h000000;
                    default: w_pattern = 24'h000000;
                endcase
            end
            2'd1: w_pattern = {r_grey1, r_grey1, r_grey1};
            2'd2: w_pattern = (r_xchk1 ^ r_ychk1) ? 24'hFFFFFF : 24'h000000;
            2'd3: w_pattern = SOLID_COLOR;
            default: w_pattern = 24'h000000;
        endcase
    end

    // Stage 2: register the colour (black outside active video) and final syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb2 <= 24'h000000;
            r_de2  <= 1'b0;
            r_hs2  <= ~SYNC_POL;
            r_vs2  <= ~SYNC_POL;
        end else begin
            r_rgb2 <= r_de1 ? w_pattern : 24'h000000;
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    assign rgb       = r_rgb2;
    assign de_out    = r_de2;
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;

endmodule

// File: tb/tb_colorbar_gen.sv
// Bench for colorbar_gen: directed frame/line sequence with randomized line
// shapes, checked every cycle against a run-length/division reference model.
module tb_colorbar_gen;

    localparam int          H     = 1280;
    localparam int          V     = 720;
    localparam int          CS    = 5;
    localparam int          GS    = 2;
    localparam logic        SP    = 1'b1;
    localparam logic [23:0] SOLID = 24'hFF0000;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = ~SP;
    logic        vsync_in = ~SP;
    logic        de_in = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;

    always #5 clk = ~clk;

    colorbar_gen dut (
        .clk       (clk),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .mode      (mode),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .de_out    (de_out)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        int          x;
        int          y;
        int          m;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         line_no  = 0;
    logic [1:0] cur_mode = 2'd0;

    // Reference model state: length of the current DE run, lines since frame start.
    int   m_run;
    int   m_y;
    int   m_mode;
    logic m_prev_de;
    logic m_prev_vs;

    function automatic logic [23:0] pattern(input int m, input int x, input int y);
        int         b;
        logic [7:0] g;
        case (m)
            0: begin
                b = x / (H / 8);
                if (b > 7) b = 7;
                return BARS[b];
            end
            1: begin
                g = 8'((x / (1 << GS)) % 256);
                return {g, g, g};
            end
            2: return ((((x / (1 << CS)) + (y / (1 << CS))) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return SOLID;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s line=%0d got=%h exp=%h", tag, line_no, got, expv);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.rgb = 24'h0; e.de = 1'b0; e.hs = ~SP; e.vs = ~SP;
        e.x = -1; e.y = 0; e.m = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0; m_y = 0; m_mode = 0;
        m_prev_de = 1'b0; m_prev_vs = ~SP;
        q.delete();
        q.push_back(idle_exp());
        q.push_back(idle_exp());
    endtask

    // One pixel clock: check the output due now, then apply the next input.
    task automatic step(input logic de, input logic hs, input logic vs);
        exp_t e;
        exp_t n;
        logic vs_edge;
        int   x;
        @(negedge clk);
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("rgb",       rgb,              e.rgb);
            check("de_out",    {23'b0, de_out},    {23'b0, e.de});
            check("hsync_out", {23'b0, hsync_out}, {23'b0, e.hs});
            check("vsync_out", {23'b0, vsync_out}, {23'b0, e.vs});
            if (e.de) begin
                if (e.m == 0 && e.x == 0)     check("bar0_white",  rgb, 24'hFFFFFF);
                if (e.m == 0 && e.x == 160)   check("bar1_yellow", rgb, 24'hFFFF00);
                if (e.m == 0 && e.x == H - 1) check("bar7_black",  rgb, 24'h000000);
                if (e.m == 1 && e.x == 4)     check("grad_x4",     rgb, 24'h010101);
                if (e.m == 1 && e.x == 1020)  check("grad_x1020",  rgb, 24'hFFFFFF);
                if (e.m == 1 && e.x == 1024)  check("grad_wrap",   rgb, 24'h000000);
                if (e.m == 2 && e.y == 0 && e.x == 31)  check("chk_y0_x31",  rgb, 24'h000000);
                if (e.m == 2 && e.y == 0 && e.x == 32)  check("chk_y0_x32",  rgb, 24'hFFFFFF);
                if (e.m == 2 && e.y == 32 && e.x == 32) check("chk_y32_x32", rgb, 24'h000000);
                if (e.m == 3)                 check("solid",       rgb, 24'hFF0000);
            end
        end
        hsync_in = hs; vsync_in = vs; de_in = de; mode = cur_mode;
        vs_edge = (vs == SP) && (m_prev_vs != SP);
        if (vs_edge) m_mode = int'(cur_mode);
        x = (m_run < H - 1) ? m_run : H - 1;
        n.de  = de; n.hs = hs; n.vs = vs;
        n.x   = de ? x : -1;
        n.y   = m_y;
        n.m   = m_mode;
        n.rgb = de ? pattern(m_mode, x, m_y) : 24'h0;
        q.push_back(n);
        m_run = de ? m_run + 1 : 0;
        if (vs_edge) m_y = 0;
        else if (m_prev_de && !de && m_y < V - 1) m_y = m_y + 1;
        m_prev_de = de;
        m_prev_vs = vs;
    endtask

    task automatic vsync_pulse(input int n);
        repeat (n) step(1'b0, ~SP, SP);
        repeat (2) step(1'b0, ~SP, ~SP);
    endtask

    task automatic line(input int len, input int hs_len, input int bp, input int fp);
        line_no++;
        $display("line %0d: mode_in=%0d de_len=%0d hs_len=%0d bp=%0d fp=%0d",
                 line_no, cur_mode, len, hs_len, bp, fp);
        repeat (hs_len) step(1'b0, SP, ~SP);
        repeat (bp)     step(1'b0, ~SP, ~SP);
        repeat (len)    step(1'b1, ~SP, ~SP);
        repeat (fp)     step(1'b0, ~SP, ~SP);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rgb",   rgb,                24'h0);
        check("rst_de",    {23'b0, de_out},    24'h0);
        check("rst_hsync", {23'b0, hsync_out}, {23'b0, ~SP});
        check("rst_vsync", {23'b0, vsync_out}, {23'b0, ~SP});
        rst = 1'b0;
        model_reset();

        // Colour bars, an oversized line, then a mid-frame mode change that must wait.
        cur_mode = 2'd0;
        vsync_pulse(3);
        line(H, 40, 20, 20);
        line(H + 20, 40, 20, 20);
        cur_mode = 2'd3;
        line(H, 40, 20, 20);
        vsync_pulse(3);
        line(H, 40, 20, 20);
        line($urandom_range(1, 200), $urandom_range(1, 40), $urandom_range(0, 8), $urandom_range(1, 8));

        // Grey gradient across a full line.
        cur_mode = 2'd1;
        vsync_pulse(2);
        line(H, 40, 20, 20);

        // Checkerboard over enough lines to cross y = 32.
        cur_mode = 2'd2;
        vsync_pulse(2);
        repeat (40) line($urandom_range(33, 80), 4, $urandom_range(0, 3), $urandom_range(1, 5));

        // One-pixel glitch lines drive y past V_ACTIVE; it must saturate.
        vsync_pulse(2);
        repeat (760) line(1, 1, 0, 1);
        line(40, 2, 1, 2);

        // Random frames with random mode and line shapes.
        repeat (4) begin
            cur_mode = 2'($urandom_range(0, 3));
            vsync_pulse($urandom_range(1, 4));
            repeat (3) begin
                line($urandom_range(1, 1400), $urandom_range(1, 40), $urandom_range(0, 10), $urandom_range(1, 10));
                cur_mode = 2'($urandom_range(0, 3));
            end
        end

        // Asynchronous reset in the middle of bar 3.
        cur_mode = 2'd0;
        vsync_pulse(2);
        repeat (5)   step(1'b0, SP, ~SP);
        repeat (500) step(1'b1, ~SP, ~SP);
        @(negedge clk);
        check("pre_rst_bar3", rgb, 24'h00FF00);
        #2 rst = 1'b1;
        #1;
        check("async_rgb",   rgb,                24'h0);
        check("async_de",    {23'b0, de_out},    24'h0);
        check("async_hsync", {23'b0, hsync_out}, {23'b0, ~SP});
        check("async_vsync", {23'b0, vsync_out}, {23'b0, ~SP});
        de_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Latched mode is back to bars even though the mode input now says checkerboard.
        cur_mode = 2'd2;
        line(H, 40, 20, 20);
        vsync_pulse(2);
        line(40, 4, 2, 4);
        repeat (4) step(1'b0, ~SP, ~SP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
